// File: rtl/shift_pipe_pkg.sv
// ============================================================================
// shift_pipe_pkg : mode encodings and popcount helper for shift_pipe
// Revision: 1.0
// ============================================================================
`default_nettype none

package shift_pipe_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_FWD  = 2'b01;
  localparam logic [1:0] MODE_BWD  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Fixed 64-bit input; callers zero-extend, so DEPTH is limited to 64.
  function automatic logic [6:0] popcount(input logic [63:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) begin
      c = c + 7'(v[i]);
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_pipe_stage.sv
// ============================================================================
// shift_stage : one {valid,data} register with hold/prev/next/load select
// Revision: 1.0
// ============================================================================
`default_nettype none

module shift_stage
  import shift_pipe_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH:0]   from_prev,
  input  logic [WIDTH:0]   from_next,
  input  logic [WIDTH:0]   load_val,
  output logic [WIDTH:0]   q,
  output logic [WIDTH:0]   q_next
);

  always_comb begin
    q_next = q;
    if (en) begin
      case (mode)
        MODE_FWD:  q_next = from_prev;
        MODE_BWD:  q_next = from_next;
        MODE_LOAD: q_next = load_val;
        default:   q_next = q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= q_next;
  end

endmodule

`default_nettype wire

// File: rtl/shift_pipe.sv
// ============================================================================
// shift_pipe : DEPTH-stage bidirectional shift pipeline with valid tracking
// Revision: 1.0
// ============================================================================
`default_nettype none

module shift_pipe
  import shift_pipe_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [1:0]               mode,
  input  logic [WIDTH-1:0]         d,
  input  logic                     d_vld,
  input  logic [WIDTH*DEPTH-1:0]   pd,
  output logic [WIDTH-1:0]         q_fwd,
  output logic [WIDTH-1:0]         q_bwd,
  output logic                     q_fwd_vld,
  output logic                     q_bwd_vld,
  output logic [WIDTH*DEPTH-1:0]   pq,
  output logic [CW-1:0]            count,
  output logic                     full,
  output logic                     empty
);

  logic [WIDTH:0]   stage_q   [DEPTH];
  logic [WIDTH:0]   stage_nxt [DEPTH];
  logic [DEPTH-1:0] vld_nxt;
  logic [WIDTH:0]   serial_in;

  assign serial_in = {d_vld, d};

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic [WIDTH:0] from_prev;
      logic [WIDTH:0] from_next;

      if (i == 0) begin : g_first
        assign from_prev = serial_in;
      end else begin : g_mid_prev
        assign from_prev = stage_q[i-1];
      end

      if (i == DEPTH - 1) begin : g_last
        assign from_next = serial_in;
      end else begin : g_mid_next
        assign from_next = stage_q[i+1];
      end

      shift_stage #(.WIDTH(WIDTH)) u_stage (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .from_prev (from_prev),
        .from_next (from_next),
        .load_val  ({1'b1, pd[i*WIDTH +: WIDTH]}),
        .q         (stage_q[i]),
        .q_next    (stage_nxt[i])
      );

      assign pq[i*WIDTH +: WIDTH] = stage_q[i][WIDTH-1:0];
      assign vld_nxt[i]           = stage_nxt[i][WIDTH];
    end
  endgenerate

  // Count tracks the post-edge valid bits so it moves in lockstep with the stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else     count <= CW'(popcount(64'(vld_nxt)));
  end

  assign q_fwd     = stage_q[DEPTH-1][WIDTH-1:0];
  assign q_fwd_vld = stage_q[DEPTH-1][WIDTH];
  assign q_bwd     = stage_q[0][WIDTH-1:0];
  assign q_bwd_vld = stage_q[0][WIDTH];
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);

endmodule

`default_nettype wire
